// File: rtl/ad9220_capture.sv
// AD9220 front end: divided sample clock, pipeline flush, boxcar average of
// 2**AVG_LOG2 conversions onto a held output register, sticky OTR flag.
module ad9220_capture #(
    parameter int CLK_FRE  = 50,
    parameter int ADC_DIV  = 10,
    parameter int AVG_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        adc_clk_o,
    input  logic [11:0] adc_data_i,
    input  logic        adc_otr_i,
    input  logic        clear_otr_i,
    output logic [11:0] ad9220_data_o,
    output logic        data_valid_o,
    output logic        otr_flag_o
);

    // state   | meaning
    // S_FLUSH | dropping the first 3 captures (converter pipeline latency)
    // S_ACC   | summing captures into acc_q
    // S_DUMP  | one clk: publish acc_q >> AVG_LOG2, restart the sum

    localparam int DIV_W = $clog2(ADC_DIV);
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ADC_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(ADC_DIV / 2);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    if (ADC_DIV < 4 || (ADC_DIV % 2) != 0 || AVG_LOG2 < 0 || AVG_LOG2 > 8 || CLK_FRE <= 0) begin : g_param_check
        $error("ad9220_capture: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_FLUSH, S_ACC, S_DUMP} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               adc_clk_q, adc_clk_d;
    logic [11:0]        in_reg_q, in_reg_d;
    logic               in_otr_q, in_otr_d;
    logic               acc_en_q, acc_en_d;
    logic [1:0]         flush_cnt_q, flush_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [11:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               otr_q, otr_d;
    logic               tick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_FLUSH;
            div_cnt_q   <= '0;
            adc_clk_q   <= 1'b0;
            in_reg_q    <= '0;
            in_otr_q    <= 1'b0;
            acc_en_q    <= 1'b0;
            flush_cnt_q <= '0;
            acc_q       <= '0;
            smp_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            otr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            adc_clk_q   <= adc_clk_d;
            in_reg_q    <= in_reg_d;
            in_otr_q    <= in_otr_d;
            acc_en_q    <= acc_en_d;
            flush_cnt_q <= flush_cnt_d;
            acc_q       <= acc_d;
            smp_cnt_q   <= smp_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            otr_q       <= otr_d;
        end
    end

    always_comb begin
        tick        = (div_cnt_q == '0);
        div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        // adc_clk tracks the counter value it will sit beside, so it stays registered
        adc_clk_d   = (div_cnt_d >= DIV_HALF);
        in_reg_d    = tick ? adc_data_i : in_reg_q;
        in_otr_d    = tick ? adc_otr_i : in_otr_q;
        acc_en_d    = tick;

        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        acc_d       = acc_q;
        smp_cnt_d   = smp_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        otr_d       = clear_otr_i ? 1'b0 : otr_q;

        case (state_q)
            S_FLUSH: begin
                if (acc_en_q) begin
                    if (flush_cnt_q == 2'd2) begin
                        flush_cnt_d = '0;
                        state_d     = S_ACC;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
            S_ACC: begin
                if (acc_en_q) begin
                    acc_d     = acc_q + ACC_W'(in_reg_q);
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    // a new OTR sample overrides a coincident clear
                    if (in_otr_q) otr_d = 1'b1;
                    if (smp_cnt_q == SMP_LAST) state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                data_d    = acc_q[AVG_LOG2 +: 12];
                valid_d   = 1'b1;
                acc_d     = '0;
                smp_cnt_d = '0;
                state_d   = S_ACC;
            end
            default: state_d = S_FLUSH;
        endcase
    end

    assign adc_clk_o     = adc_clk_q;
    assign ad9220_data_o = data_q;
    assign data_valid_o  = valid_q;
    assign otr_flag_o    = otr_q;

endmodule
